// File: rtl/csc_encode_ctrl_if.sv
// Bus between the CSC encode controller and its dense-source SRAM read port plus the CSC encoder.
interface csc_encode_ctrl_if #(
  parameter int SRAM_AW = 10
);
  logic                sram_rd_en;
  logic [SRAM_AW-1:0]  sram_rd_addr;
  logic [7:0]          sram_rd_data;
  logic                enc_data_in_valid;
  logic signed [7:0]   enc_data_in;
  logic                enc_data_in_ready;
  logic [4:0]          enc_matrix_height;
  logic [4:0]          enc_matrix_width;
  logic                enc_clear_iact_SRAM;
  logic                enc_one_vector_done;

  modport master (
    output sram_rd_en, sram_rd_addr, enc_data_in_valid, enc_data_in,
           enc_matrix_height, enc_matrix_width, enc_clear_iact_SRAM,
    input  sram_rd_data, enc_data_in_ready, enc_one_vector_done
  );

  modport slave (
    input  sram_rd_en, sram_rd_addr, enc_data_in_valid, enc_data_in,
           enc_matrix_height, enc_matrix_width, enc_clear_iact_SRAM,
    output sram_rd_data, enc_data_in_ready, enc_one_vector_done
  );
endinterface

// File: rtl/csc_encode_ctrl.sv
// Batch sequencer for the CSC encoder: clears, streams each dense matrix column-major through a
// 2-entry skid buffer, then waits (with a watchdog) for the encoder's end-of-vector indication.
module csc_encode_ctrl #(
  parameter int SRAM_AW        = 10,
  parameter int VEC_W          = 6,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [SRAM_AW-1:0] cfg_base_addr,
  input  logic [VEC_W-1:0]   cfg_num_vectors,
  input  logic [4:0]         cfg_height,
  input  logic [4:0]         cfg_width,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [VEC_W-1:0]   vector_index,
  csc_encode_ctrl_if.master  bus
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_DRAIN, S_WAIT_DONE, S_NEXT} state_t;

  state_t             state_q, state_d;
  logic [4:0]         h_q, h_d, w_q, w_d, row_q, row_d, col_q, col_d;
  logic [VEC_W-1:0]   n_q, n_d, v_q, v_d;
  logic [SRAM_AW-1:0] vec_base_q, vec_base_d, col_base_q, col_base_d, addr_q, addr_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               pend_q, pend_d, error_q, error_d, done_q, done_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]         mem_q [2];
  logic [7:0]         mem_d [2];

  logic       rd_en, clear, out_valid, accept, push, pop, space, last_row, last_col;
  logic [7:0] out_data;

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    w_d        = w_q;
    n_d        = n_q;
    v_d        = v_q;
    row_d      = row_q;
    col_d      = col_q;
    vec_base_d = vec_base_q;
    col_base_d = col_base_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    error_d    = error_q;
    done_d     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    rd_en      = 1'b0;
    clear      = 1'b0;

    // Skid buffer with fall-through: returning data bypasses the FIFO when it is empty.
    out_valid = (cnt_q != 2'd0) || pend_q;
    out_data  = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : bus.sram_rd_data;
    accept    = out_valid && bus.enc_data_in_ready;
    pop       = accept && (cnt_q != 2'd0);
    push      = pend_q && !(accept && (cnt_q == 2'd0));
    if (push) begin
      mem_d[wr_ptr_q] = bus.sram_rd_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    space = (3'(cnt_q) + 3'(pend_q)) < 3'd2;

    last_row = (row_q == h_q - 5'd1);
    last_col = (col_q == w_q - 5'd1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          h_d        = cfg_height;
          w_d        = cfg_width;
          n_d        = (cfg_num_vectors == '0) ? VEC_W'(1) : cfg_num_vectors;
          vec_base_d = cfg_base_addr;
          v_d        = '0;
          error_d    = 1'b0;
          if (cfg_height == 5'd0 || cfg_width == 5'd0) begin
            error_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        clear      = 1'b1;
        row_d      = '0;
        col_d      = '0;
        col_base_d = vec_base_q;
        addr_d     = vec_base_q;
        state_d    = S_FETCH;
      end
      S_FETCH: begin
        if (space) begin
          rd_en = 1'b1;
          if (last_row) begin
            row_d      = '0;
            col_d      = col_q + 5'd1;
            col_base_d = col_base_q + SRAM_AW'(1);
            addr_d     = col_base_q + SRAM_AW'(1);
            // The element after (H-1, W-1) is where the next matrix begins.
            if (last_col) begin
              vec_base_d = addr_q + SRAM_AW'(1);
              state_d    = S_DRAIN;
            end
          end else begin
            row_d  = row_q + 5'd1;
            addr_d = addr_q + SRAM_AW'(w_q);
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == 2'd0 && !pend_q) begin
          wd_d    = '0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.enc_one_vector_done) begin
          state_d = S_NEXT;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_NEXT: begin
        if (v_q == n_q - VEC_W'(1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          v_d     = v_q + VEC_W'(1);
          state_d = S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pend_d = rd_en;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      h_q        <= '0;
      w_q        <= '0;
      n_q        <= '0;
      v_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      vec_base_q <= '0;
      col_base_q <= '0;
      addr_q     <= '0;
      wd_q       <= '0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      w_q        <= w_d;
      n_q        <= n_d;
      v_q        <= v_d;
      row_q      <= row_d;
      col_q      <= col_d;
      vec_base_q <= vec_base_d;
      col_base_q <= col_base_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      error_q    <= error_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign busy                    = (state_q != S_IDLE);
  assign done                    = done_q;
  assign error                   = error_q;
  assign vector_index            = v_q;
  assign bus.sram_rd_en          = rd_en;
  assign bus.sram_rd_addr        = rd_en ? addr_q : '0;
  assign bus.enc_data_in_valid   = out_valid;
  assign bus.enc_data_in         = out_valid ? out_data : 8'sd0;
  assign bus.enc_matrix_height   = h_q;
  assign bus.enc_matrix_width    = w_q;
  assign bus.enc_clear_iact_SRAM = clear;
endmodule

// File: tb/tb_csc_encode_ctrl.sv
// Directed bench for csc_encode_ctrl: a registered SRAM model answers reads, a per-cycle runner
// drives the encoder handshake, and each test task checks the logged traffic against hand values.
module tb_csc_encode_ctrl;
  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] cfg_base_addr;
  logic [5:0] cfg_num_vectors;
  logic [4:0] cfg_height, cfg_width;
  logic       busy, done, error;
  logic [5:0] vector_index;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  csc_encode_ctrl_if #(.SRAM_AW(10)) bus ();

  csc_encode_ctrl #(.SRAM_AW(10), .VEC_W(6), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_num_vectors(cfg_num_vectors),
    .cfg_height(cfg_height), .cfg_width(cfg_width),
    .busy(busy), .done(done), .error(error), .vector_index(vector_index),
    .bus(bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] fdat(input logic [9:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd7 + 32'd3;
    return t[7:0];
  endfunction

  always @(posedge clock) bus.sram_rd_data <= bus.sram_rd_en ? fdat(bus.sram_rd_addr) : 8'h00;

  int         rd_cyc[$];
  logic [9:0] rd_addr[$];
  logic [7:0] acc_dat[$];
  int         acc_cyc[$];
  int         clr_cyc[$];
  logic [5:0] clr_vidx[$];
  int         done_cyc[$];
  int         max_occ, s_cyc;
  logic       err_at_done, err_first;

  task automatic run(input logic [4:0] h, input logic [4:0] w, input logic [5:0] n,
                     input logic [9:0] base, input int stall_after, input int stall_len,
                     input bit give_vdone, input int restart_at, input int max_cyc);
    int consumed, stall_used, occ;
    rd_cyc.delete(); rd_addr.delete(); acc_dat.delete(); acc_cyc.delete();
    clr_cyc.delete(); clr_vidx.delete(); done_cyc.delete();
    max_occ = 0; consumed = 0; stall_used = 0; err_at_done = 1'bx; err_first = 1'bx;
    @(negedge clock);
    cfg_height = h; cfg_width = w; cfg_num_vectors = n; cfg_base_addr = base;
    start = 1'b1; s_cyc = cyc; bus.enc_data_in_ready = 1'b1;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clock);
      start = (k + 1 == restart_at);
      cfg_height = h ^ 5'h15; cfg_width = w ^ 5'h0A; cfg_base_addr = ~base; cfg_num_vectors = n + 6'd3;
      if (k == 0) err_first = error;
      occ = rd_cyc.size() - acc_cyc.size();
      if (occ > max_occ) max_occ = occ;
      bus.enc_data_in_ready = !(stall_len > 0 && acc_cyc.size() >= stall_after && stall_used < stall_len);
      if (!bus.enc_data_in_ready) stall_used++;
      if (bus.sram_rd_en) begin rd_cyc.push_back(cyc - s_cyc); rd_addr.push_back(bus.sram_rd_addr); end
      if (bus.enc_data_in_valid && bus.enc_data_in_ready) begin
        acc_dat.push_back(bus.enc_data_in); acc_cyc.push_back(cyc - s_cyc); consumed++;
      end
      if (bus.enc_clear_iact_SRAM) begin clr_cyc.push_back(cyc - s_cyc); clr_vidx.push_back(vector_index); consumed = 0; end
      if (done) begin done_cyc.push_back(cyc - s_cyc); err_at_done = error; end
      bus.enc_one_vector_done = give_vdone && (consumed == int'(h) * int'(w));
      if (done) break;
    end
    bus.enc_one_vector_done = 1'b0; bus.enc_data_in_ready = 1'b1; start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL reset_done_err got=%b%b want=00", done, error); end
    total++; if (bus.sram_rd_en !== 1'b0 || bus.enc_clear_iact_SRAM !== 1'b0 || bus.enc_data_in_valid !== 1'b0)
      begin bad++; $display("FAIL reset_strobes got=%b%b%b want=000", bus.sram_rd_en, bus.enc_clear_iact_SRAM, bus.enc_data_in_valid); end
    total++; if ({bus.enc_matrix_height, bus.enc_matrix_width, vector_index} !== 16'h0)
      begin bad++; $display("FAIL reset_hw_vidx got=%h want=0", {bus.enc_matrix_height, bus.enc_matrix_width, vector_index}); end
  endtask

  task automatic test_single();
    logic [9:0] ea [6];
    int g;
    ea = '{10'h10, 10'h12, 10'h14, 10'h11, 10'h13, 10'h15};
    run(5'd3, 5'd2, 6'd1, 10'h10, 0, 0, 1'b1, -1, 60);
    total++; if (rd_addr.size() !== 6) begin bad++; $display("FAIL single_nreads got=%0d want=6", rd_addr.size()); end
    for (int i = 0; i < 6; i++) begin
      g = (i < rd_addr.size()) ? int'(rd_addr[i]) : -1;
      total++; if (g !== int'(ea[i])) begin bad++; $display("FAIL single_addr[%0d] got=%0h want=%0h", i, g, ea[i]); end
      g = (i < rd_cyc.size()) ? rd_cyc[i] : -1;
      total++; if (g !== 2 + i) begin bad++; $display("FAIL single_rdcyc[%0d] got=%0d want=%0d", i, g, 2 + i); end
      g = (i < acc_dat.size()) ? int'(acc_dat[i]) : -1;
      total++; if (g !== int'(fdat(ea[i]))) begin bad++; $display("FAIL single_data[%0d] got=%0h want=%0h", i, g, fdat(ea[i])); end
      g = (i < acc_cyc.size()) ? acc_cyc[i] : -1;
      total++; if (g !== 3 + i) begin bad++; $display("FAIL single_acccyc[%0d] got=%0d want=%0d", i, g, 3 + i); end
    end
    g = (clr_cyc.size() == 1) ? clr_cyc[0] : -1;
    total++; if (g !== 1) begin bad++; $display("FAIL single_clear got=%0d want=1", g); end
    g = (done_cyc.size() == 1) ? done_cyc[0] : -1;
    total++; if (g !== 12) begin bad++; $display("FAIL single_done got=%0d want=12", g); end
    total++; if (err_at_done !== 1'b0) begin bad++; $display("FAIL single_err got=%b want=0", err_at_done); end
    total++; if (bus.enc_matrix_height !== 5'd3 || bus.enc_matrix_width !== 5'd2)
      begin bad++; $display("FAIL single_hw got=%0d/%0d want=3/2", bus.enc_matrix_height, bus.enc_matrix_width); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_multi_vector();
    logic [9:0] ea [8];
    int         ec [8];
    int g;
    ea = '{10'd0, 10'd2, 10'd1, 10'd3, 10'd4, 10'd6, 10'd5, 10'd7};
    ec = '{2, 3, 4, 5, 11, 12, 13, 14};
    run(5'd2, 5'd2, 6'd2, 10'h000, 0, 0, 1'b1, -1, 80);
    total++; if (rd_addr.size() !== 8) begin bad++; $display("FAIL multi_nreads got=%0d want=8", rd_addr.size()); end
    for (int i = 0; i < 8; i++) begin
      g = (i < rd_addr.size()) ? int'(rd_addr[i]) : -1;
      total++; if (g !== int'(ea[i])) begin bad++; $display("FAIL multi_addr[%0d] got=%0d want=%0d", i, g, ea[i]); end
      g = (i < rd_cyc.size()) ? rd_cyc[i] : -1;
      total++; if (g !== ec[i]) begin bad++; $display("FAIL multi_rdcyc[%0d] got=%0d want=%0d", i, g, ec[i]); end
      g = (i < acc_dat.size()) ? int'(acc_dat[i]) : -1;
      total++; if (g !== int'(fdat(ea[i]))) begin bad++; $display("FAIL multi_data[%0d] got=%0h want=%0h", i, g, fdat(ea[i])); end
    end
    total++; if (clr_cyc.size() !== 2) begin bad++; $display("FAIL multi_nclear got=%0d want=2", clr_cyc.size()); end
    g = (clr_cyc.size() == 2) ? clr_cyc[1] : -1;
    total++; if (g !== 10) begin bad++; $display("FAIL multi_clear2 got=%0d want=10", g); end
    g = (clr_vidx.size() == 2) ? int'({clr_vidx[0], clr_vidx[1]}) : -1;
    total++; if (g !== 1) begin bad++; $display("FAIL multi_vidx got=%0h want=001", g); end
    g = (done_cyc.size() == 1) ? done_cyc[0] : -1;
    total++; if (g !== 19) begin bad++; $display("FAIL multi_done got=%0d want=19", g); end
    total++; if (vector_index !== 6'd1) begin bad++; $display("FAIL multi_vidx_hold got=%0d want=1", vector_index); end
  endtask

  task automatic test_backpressure();
    logic [9:0] a;
    int g;
    run(5'd4, 5'd4, 6'd1, 10'h3FA, 3, 5, 1'b1, -1, 120);
    total++; if (rd_addr.size() !== 16 || acc_dat.size() !== 16)
      begin bad++; $display("FAIL bp_counts got=%0d/%0d want=16/16", rd_addr.size(), acc_dat.size()); end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        a = 10'h3FA + 10'(r * 4 + c);
        g = (c * 4 + r < rd_addr.size()) ? int'(rd_addr[c * 4 + r]) : -1;
        total++; if (g !== int'(a)) begin bad++; $display("FAIL bp_addr[%0d] got=%0h want=%0h", c * 4 + r, g, a); end
        g = (c * 4 + r < acc_dat.size()) ? int'(acc_dat[c * 4 + r]) : -1;
        total++; if (g !== int'(fdat(a))) begin bad++; $display("FAIL bp_data[%0d] got=%0h want=%0h", c * 4 + r, g, fdat(a)); end
      end
    total++; if (max_occ > 2) begin bad++; $display("FAIL bp_occupancy got=%0d want<=2", max_occ); end
    total++; if (done_cyc.size() !== 1) begin bad++; $display("FAIL bp_done got=%0d want=1", done_cyc.size()); end
  endtask

  task automatic test_timeout();
    int g;
    run(5'd2, 5'd1, 6'd1, 10'h020, 0, 0, 1'b0, -1, 60);
    g = (done_cyc.size() == 1) ? done_cyc[0] : -1;
    total++; if (g !== 14) begin bad++; $display("FAIL to_done got=%0d want=14", g); end
    total++; if (err_at_done !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", err_at_done); end
    repeat (3) @(negedge clock);
    total++; if (error !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL to_sticky got=%b%b want=10", error, busy); end
    run(5'd1, 5'd1, 6'd0, 10'h030, 0, 0, 1'b1, -1, 40);
    total++; if (err_first !== 1'b0) begin bad++; $display("FAIL to_restart_clr got=%b want=0", err_first); end
    total++; if (done_cyc.size() !== 1 || err_at_done !== 1'b0)
      begin bad++; $display("FAIL to_restart_run got=%0d/%b want=1/0", done_cyc.size(), err_at_done); end
    g = (rd_addr.size() == 1) ? int'(rd_addr[0]) : -1;
    total++; if (g !== 'h30) begin bad++; $display("FAIL to_restart_addr got=%0h want=30", g); end
  endtask

  task automatic test_zero_dims();
    int g;
    run(5'd0, 5'd3, 6'd1, 10'h040, 0, 0, 1'b1, -1, 20);
    g = (done_cyc.size() == 1) ? done_cyc[0] : -1;
    total++; if (g !== 1 || err_at_done !== 1'b1) begin bad++; $display("FAIL zh_done got=%0d/%b want=1/1", g, err_at_done); end
    total++; if (rd_addr.size() !== 0 || clr_cyc.size() !== 0)
      begin bad++; $display("FAIL zh_activity got=%0d/%0d want=0/0", rd_addr.size(), clr_cyc.size()); end
    run(5'd2, 5'd0, 6'd1, 10'h040, 0, 0, 1'b1, -1, 20);
    g = (done_cyc.size() == 1) ? done_cyc[0] : -1;
    total++; if (g !== 1 || err_at_done !== 1'b1 || rd_addr.size() !== 0)
      begin bad++; $display("FAIL zw_done got=%0d/%b/%0d want=1/1/0", g, err_at_done, rd_addr.size()); end
  endtask

  task automatic test_reset_midrun();
    int ndone;
    @(negedge clock);
    cfg_height = 5'd4; cfg_width = 5'd4; cfg_num_vectors = 6'd1; cfg_base_addr = 10'h080; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (bus.sram_rd_en !== 1'b1) begin bad++; $display("FAIL mid_fetching got=%b want=1", bus.sram_rd_en); end
    reset = 1'b1;
    @(negedge clock);
    total++; if ({busy, done, error, vector_index, bus.sram_rd_en, bus.sram_rd_addr, bus.enc_data_in_valid,
                  bus.enc_data_in, bus.enc_clear_iact_SRAM, bus.enc_matrix_height, bus.enc_matrix_width} !== '0)
      begin bad++; $display("FAIL mid_reset_outs got=%b%b%b vidx=%0d rd=%b addr=%0h v=%b d=%0h clr=%b h=%0d w=%0d want=all0",
        busy, done, error, vector_index, bus.sram_rd_en, bus.sram_rd_addr, bus.enc_data_in_valid,
        bus.enc_data_in, bus.enc_clear_iact_SRAM, bus.enc_matrix_height, bus.enc_matrix_width); end
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clock); if (done || busy) ndone++; end
    total++; if (ndone !== 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", ndone); end
  endtask

  task automatic test_start_while_busy();
    int g;
    run(5'd2, 5'd2, 6'd1, 10'h100, 0, 0, 1'b1, 3, 60);
    g = (rd_addr.size() == 4) ? int'({rd_addr[0], rd_addr[1], rd_addr[2], rd_addr[3]}) : -1;
    total++; if (g !== int'({10'h100, 10'h102, 10'h101, 10'h103}))
      begin bad++; $display("FAIL busy_start_addrs got=%0h want=%0h", g, {10'h100, 10'h102, 10'h101, 10'h103}); end
    g = (done_cyc.size() == 1) ? done_cyc[0] : -1;
    total++; if (g !== 10 || clr_cyc.size() !== 1)
      begin bad++; $display("FAIL busy_start_done got=%0d/%0d want=10/1", g, clr_cyc.size()); end
    total++; if (bus.enc_matrix_height !== 5'd2 || bus.enc_matrix_width !== 5'd2)
      begin bad++; $display("FAIL busy_start_hw got=%0d/%0d want=2/2", bus.enc_matrix_height, bus.enc_matrix_width); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    cfg_base_addr = '0; cfg_num_vectors = '0; cfg_height = '0; cfg_width = '0;
    bus.enc_data_in_ready = 1'b1; bus.enc_one_vector_done = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_single();
    test_multi_vector();
    test_backpressure();
    test_timeout();
    test_zero_dims();
    test_reset_midrun();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached t=%0t", $time);
    $fatal(1);
  end
endmodule
